control_unit_p: RTL and testbench

CONTROL_UNIT_P -- requirements
Module: control_unit_p

---
 rtl/control_unit_p_if.sv | 42 ++++
 rtl/control_unit_p.sv | 251 +++++++++++++++++++++++++
 tb/tb_control_unit_p.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_p_if.sv
// Controller <-> fetch/datapath/data-memory bundle; the controller sits on the
// master side, the datapath (or a bench) on the slave side.
interface control_unit_p_if #(
  parameter int unsigned IW = 24,
  parameter int unsigned RW = 4,
  parameter int unsigned AW = 8,
  parameter int unsigned CW = 16
);
  logic [IW-1:0] instr;
  logic          imem_ready;
  logic          dmem_ready;
  logic          z;

  logic          imem_req;
  logic          pc_inc;
  logic          pc_load;
  logic [AW-1:0] pc_target;
  logic [1:0]    alu_op;
  logic [RW-1:0] rpa;
  logic [RW-1:0] rpb;
  logic [RW-1:0] wpn;
  logic          reg_we;
  logic [1:0]    wb_sel;
  logic          dmem_re;
  logic          dmem_we;
  logic [AW-1:0] imm;
  logic          halted;
  logic          illegal;
  logic [CW-1:0] retired;

  modport master (
    input  instr, imem_ready, dmem_ready, z,
    output imem_req, pc_inc, pc_load, pc_target, alu_op, rpa, rpb, wpn,
           reg_we, wb_sel, dmem_re, dmem_we, imm, halted, illegal, retired
  );

  modport slave (
    output instr, imem_ready, dmem_ready, z,
    input  imem_req, pc_inc, pc_load, pc_target, alu_op, rpa, rpb, wpn,
           reg_we, wb_sel, dmem_re, dmem_we, imm, halted, illegal, retired
  );
endinterface

// File: rtl/control_unit_p.sv
// Multi-cycle sequencing controller: fetch / decode / execute with data-memory
// wait states; datapath strobes are decoded from the current state and IR.
module control_unit_p #(
  parameter int unsigned IW = 24,
  parameter int unsigned RW = 4,
  parameter int unsigned AW = 8,
  parameter int unsigned CW = 16
) (
  input logic              clk,
  input logic              rst_n,
  control_unit_p_if.master bus
);

  localparam int unsigned OP_W   = 4;
  localparam int unsigned OP_LSB = IW - OP_W;
  localparam int unsigned RA_LSB = OP_LSB - RW;
  localparam int unsigned RB_LSB = RA_LSB - RW;

  localparam logic [OP_W-1:0] OP_NOP   = 4'b0000;
  localparam logic [OP_W-1:0] OP_HALT  = 4'b0001;
  localparam logic [OP_W-1:0] OP_LOADI = 4'b0100;
  localparam logic [OP_W-1:0] OP_MUL   = 4'b0101;
  localparam logic [OP_W-1:0] OP_LOAD  = 4'b0110;
  localparam logic [OP_W-1:0] OP_MV    = 4'b0111;
  localparam logic [OP_W-1:0] OP_ADD   = 4'b1000;
  localparam logic [OP_W-1:0] OP_INC   = 4'b1001;
  localparam logic [OP_W-1:0] OP_SUB   = 4'b1010;
  localparam logic [OP_W-1:0] OP_JMPZ  = 4'b1011;
  localparam logic [OP_W-1:0] OP_JMP   = 4'b1100;
  localparam logic [OP_W-1:0] OP_STORE = 4'b1101;

  localparam logic [1:0] ALU_NONE = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] ALU_MUL  = 2'b11;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_DMEM = 2'b01;
  localparam logic [1:0] WB_IMM  = 2'b10;
  localparam logic [1:0] WB_RPA  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [IW-1:0]   ir_q;
  logic [CW-1:0]   retired_q;

  logic [OP_W-1:0] op;
  logic [RW-1:0]   ra;
  logic [RW-1:0]   rb;
  logic [AW-1:0]   imm_f;
  logic            fetch_hit_c;
  logic            retire_c;

  logic            imem_req_c;
  logic            pc_inc_c;
  logic            pc_load_c;
  logic [AW-1:0]   pc_target_c;
  logic [1:0]      alu_op_c;
  logic [RW-1:0]   rpa_c;
  logic [RW-1:0]   rpb_c;
  logic [RW-1:0]   wpn_c;
  logic            reg_we_c;
  logic [1:0]      wb_sel_c;
  logic            dmem_re_c;
  logic            dmem_we_c;
  logic            halted_c;
  logic            illegal_c;

  // IR field slicing
  assign op    = ir_q[OP_LSB +: OP_W];
  assign ra    = ir_q[RA_LSB +: RW];
  assign rb    = ir_q[RB_LSB +: RW];
  assign imm_f = ir_q[AW-1:0];

  if (RB_LSB > AW) begin : g_ir_pad
    logic unused_ir_pad;
    assign unused_ir_pad = ^ir_q[RB_LSB-1:AW];
  end

  // Where DECODE sends each opcode; anything unlisted is an illegal opcode.
  function automatic state_t decode_target(input logic [OP_W-1:0] o);
    state_t t;
    case (o)
      OP_HALT:                                   t = S_HALT;
      OP_NOP, OP_LOADI, OP_MUL, OP_MV, OP_ADD,
      OP_INC, OP_SUB, OP_JMPZ, OP_JMP:           t = S_EXEC;
      OP_LOAD, OP_STORE:                         t = S_MEM;
      default:                                   t = S_TRAP;
    endcase
    return t;
  endfunction

  assign fetch_hit_c = (state_q == S_FETCH) && bus.imem_ready;

  // An instruction retires when its last state completes
  assign retire_c = (state_q == S_EXEC) ||
                    (state_q == S_WB) ||
                    ((state_q == S_MEM) && (op == OP_STORE) && bus.dmem_ready);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (bus.imem_ready) state_d = S_DECODE;
      S_DECODE: state_d = decode_target(op);
      S_EXEC:   state_d = S_FETCH;
      S_MEM: begin
        if (bus.dmem_ready) begin
          state_d = (op == OP_LOAD) ? S_WB : S_FETCH;
        end
      end
      S_WB:     state_d = S_FETCH;
      default:  state_d = state_q;
    endcase
  end

  // Instruction register captured on the accepted fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q <= '0;
    end else if (fetch_hit_c) begin
      ir_q <= bus.instr;
    end
  end

  // Saturating retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else if (retire_c && (retired_q != {CW{1'b1}})) begin
      retired_q <= retired_q + CW'(1);
    end
  end

  // Output decode from state and IR
  always_comb begin
    imem_req_c  = 1'b0;
    pc_inc_c    = 1'b0;
    pc_load_c   = 1'b0;
    pc_target_c = '0;
    alu_op_c    = ALU_NONE;
    rpa_c       = '0;
    rpb_c       = '0;
    wpn_c       = '0;
    reg_we_c    = 1'b0;
    wb_sel_c    = WB_ALU;
    dmem_re_c   = 1'b0;
    dmem_we_c   = 1'b0;
    halted_c    = 1'b0;
    illegal_c   = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        pc_inc_c   = bus.imem_ready;
      end
      S_EXEC: begin
        case (op)
          OP_LOADI: begin
            reg_we_c = 1'b1;
            wpn_c    = ra;
            wb_sel_c = WB_IMM;
          end
          OP_MUL, OP_ADD, OP_SUB: begin
            alu_op_c = (op == OP_MUL) ? ALU_MUL : ((op == OP_ADD) ? ALU_ADD : ALU_SUB);
            rpa_c    = ra;
            rpb_c    = rb;
            reg_we_c = 1'b1;
            wpn_c    = ra;
            wb_sel_c = WB_ALU;
          end
          OP_INC: begin
            // the all-ones register index reads back a constant one
            alu_op_c = ALU_ADD;
            rpa_c    = ra;
            rpb_c    = {RW{1'b1}};
            reg_we_c = 1'b1;
            wpn_c    = ra;
            wb_sel_c = WB_ALU;
          end
          OP_MV: begin
            rpa_c    = ra;
            reg_we_c = 1'b1;
            wpn_c    = rb;
            wb_sel_c = WB_RPA;
          end
          OP_JMP: begin
            pc_load_c   = 1'b1;
            pc_target_c = imm_f;
          end
          OP_JMPZ: begin
            pc_load_c   = bus.z;
            pc_target_c = imm_f;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        rpa_c     = ra;
        dmem_re_c = (op == OP_LOAD);
        dmem_we_c = (op == OP_STORE);
      end
      S_WB: begin
        reg_we_c = 1'b1;
        wpn_c    = rb;
        wb_sel_c = WB_DMEM;
      end
      S_HALT:  halted_c  = 1'b1;
      S_TRAP:  illegal_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.imem_req  = imem_req_c;
  assign bus.pc_inc    = pc_inc_c;
  assign bus.pc_load   = pc_load_c;
  assign bus.pc_target = pc_target_c;
  assign bus.alu_op    = alu_op_c;
  assign bus.rpa       = rpa_c;
  assign bus.rpb       = rpb_c;
  assign bus.wpn       = wpn_c;
  assign bus.reg_we    = reg_we_c;
  assign bus.wb_sel    = wb_sel_c;
  assign bus.dmem_re   = dmem_re_c;
  assign bus.dmem_we   = dmem_we_c;
  assign bus.imm       = imm_f;
  assign bus.halted    = halted_c;
  assign bus.illegal   = illegal_c;
  assign bus.retired   = retired_q;

endmodule

// File: tb/tb_control_unit_p.sv
// Bench for control_unit_p: directed scenarios plus random instruction streams
// checked cycle by cycle against an instruction-level expectation queue.
module tb_control_unit_p;
  localparam int unsigned IW = 24;
  localparam int unsigned RW = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned CW = 16;

  localparam logic [3:0] NOP = 4'h0, HLT = 4'h1, LDI = 4'h4, MUL = 4'h5, LD = 4'h6,
                         MV = 4'h7, ADD = 4'h8, INC = 4'h9, SUB = 4'hA, JZ = 4'hB,
                         JMP = 4'hC, ST = 4'hD;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  control_unit_p_if #(.IW(IW), .RW(RW), .AW(AW), .CW(CW)) bus ();
  control_unit_p_if #(.IW(IW), .RW(RW), .AW(AW), .CW(2))  bus2 ();

  control_unit_p #(.IW(IW), .RW(RW), .AW(AW), .CW(CW)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  control_unit_p #(.IW(IW), .RW(RW), .AW(AW), .CW(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        ir_rdy;
    logic        dm_rdy;
    logic        z;
    logic [23:0] instr;
    logic [31:0] exp;
    logic [15:0] ret;
    logic [7:0]  imm;
  } cyc_t;

  cyc_t q[$];
  int          ret_m;
  logic [7:0]  imm_m;

  // Output snapshot: req inc ld tgt alu rpa rpb wpn we sel re dwe halted illegal
  function automatic logic [31:0] pk(input logic req, inc, ld, input logic [7:0] tgt,
                                     input logic [1:0] alu, input logic [3:0] a, b, w,
                                     input logic we, input logic [1:0] sel,
                                     input logic re, dwe, h, il);
    return {req, inc, ld, tgt, alu, a, b, w, we, sel, re, dwe, h, il};
  endfunction

  function automatic logic [31:0] outs();
    return {bus.imem_req, bus.pc_inc, bus.pc_load, bus.pc_target, bus.alu_op, bus.rpa,
            bus.rpb, bus.wpn, bus.reg_we, bus.wb_sel, bus.dmem_re, bus.dmem_we,
            bus.halted, bus.illegal};
  endfunction

  function automatic logic [23:0] mk(input logic [3:0] op, ra, rb, input logic [7:0] imm);
    return {op, ra, rb, 4'($urandom), imm};
  endfunction

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.imem_ready = 1'b0;  bus.dmem_ready = 1'b0;  bus.z = 1'b0;  bus.instr = '0;
    bus2.imem_ready = 1'b0; bus2.dmem_ready = 1'b0; bus2.z = 1'b0; bus2.instr = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Present one instruction in FETCH with imem_ready in the first cycle
  task automatic fetch(input logic [23:0] word);
    bus.imem_ready = 1'b1;
    bus.instr      = word;
    step();
    bus.imem_ready = 1'b0;
    bus.instr      = 24'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    n_checks++;
    if ({outs(), bus.retired, bus.imm} !== 56'd0)
      $display("FAIL reset_outputs: got %h required 0", {outs(), bus.retired, bus.imm});
    else n_pass++;
    step();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (outs() !== 32'd0) $display("FAIL reset_idle: got %h required 0", outs());
    else n_pass++;
    step();
    #1;
    n_checks++;
    if (outs() !== pk(1,0,0,8'h0,2'b0,4'h0,4'h0,4'h0,0,2'b0,0,0,0,0))
      $display("FAIL reset_then_fetch: got %h", outs());
    else n_pass++;
    step();
  endtask

  task automatic test_add();
    apply_reset();
    bus.imem_ready = 1'b1;
    bus.instr      = mk(ADD, 4'd3, 4'd5, 8'h11);
    #1;
    n_checks++;
    if (outs() !== pk(1,1,0,8'h0,2'b0,4'h0,4'h0,4'h0,0,2'b0,0,0,0,0))
      $display("FAIL add_fetch_pc_inc: got %h", outs());
    else n_pass++;
    step();
    bus.imem_ready = 1'b0;
    #1;
    n_checks++;
    if ({outs(), bus.imm} !== {32'd0, 8'h11})
      $display("FAIL add_decode: got %h required %h", {outs(), bus.imm}, {32'd0, 8'h11});
    else n_pass++;
    step();
    #1;
    n_checks++;
    if ({outs(), bus.retired} !== {pk(0,0,0,8'h0,2'b01,4'd3,4'd5,4'd3,1,2'b00,0,0,0,0), 16'd0})
      $display("FAIL add_exec: got %h retired %0d", outs(), bus.retired);
    else n_pass++;
    step();
    #1;
    n_checks++;
    if ({bus.imem_req, bus.reg_we, bus.retired} !== {1'b1, 1'b0, 16'd1})
      $display("FAIL add_back_to_fetch: req %b we %b retired %0d required 1 0 1",
               bus.imem_req, bus.reg_we, bus.retired);
    else n_pass++;
    step();
  endtask

  task automatic test_jmpz();
    for (int zz = 0; zz < 2; zz++) begin
      apply_reset();
      fetch(mk(JZ, 4'($urandom), 4'($urandom), 8'h2A));
      step();
      bus.z = zz[0];
      #1;
      n_checks++;
      if ({bus.pc_load, bus.pc_target, bus.reg_we} !== {zz[0], 8'h2A, 1'b0})
        $display("FAIL jmpz_exec_z%0d: load %b target %h", zz, bus.pc_load, bus.pc_target);
      else n_pass++;
      step();
      #1;
      n_checks++;
      if ({bus.pc_load, bus.imem_req} !== 2'b01)
        $display("FAIL jmpz_one_cycle_z%0d: load %b req %b", zz, bus.pc_load, bus.imem_req);
      else n_pass++;
      bus.z = 1'b0;
      step();
    end
  endtask

  task automatic test_load_wait();
    int cnt;
    apply_reset();
    fetch(mk(LD, 4'd2, 4'd7, 8'h40));
    step();
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      bus.dmem_ready = (i == 4);
      bus.imem_ready = rnd();
      #1;
      if (bus.dmem_re && !bus.dmem_we && !bus.reg_we && bus.rpa == 4'd2) cnt++;
      step();
    end
    bus.dmem_ready = 1'b0;
    bus.imem_ready = 1'b0;
    n_checks++;
    if (cnt !== 5) $display("FAIL load_dmem_re_cycles: got %0d required 5", cnt);
    else n_pass++;
    #1;
    n_checks++;
    if ({outs(), bus.retired} !== {pk(0,0,0,8'h0,2'b0,4'h0,4'h0,4'd7,1,2'b01,0,0,0,0), 16'd0})
      $display("FAIL load_wb: got %h retired %0d", outs(), bus.retired);
    else n_pass++;
    step();
    #1;
    n_checks++;
    if ({bus.imem_req, bus.reg_we, bus.dmem_re, bus.retired} !== {3'b100, 16'd1})
      $display("FAIL load_after_wb: req %b we %b re %b retired %0d",
               bus.imem_req, bus.reg_we, bus.dmem_re, bus.retired);
    else n_pass++;
    step();
  endtask

  task automatic test_absorbing();
    logic [3:0] ops [2];
    int good;
    ops[0] = 4'hF;
    ops[1] = HLT;
    for (int k = 0; k < 2; k++) begin
      apply_reset();
      fetch(mk(ops[k], 4'($urandom), 4'($urandom), 8'($urandom)));
      step();
      good = 0;
      for (int i = 0; i < 20; i++) begin
        bus.imem_ready = rnd();
        bus.dmem_ready = rnd();
        bus.z          = rnd();
        #1;
        if (outs() === pk(0,0,0,8'h0,2'b0,4'h0,4'h0,4'h0,0,2'b0,0,0,k == 1,k == 0)) good++;
        step();
      end
      n_checks++;
      if ({32'(good), bus.retired} !== {32'd20, 16'd0})
        $display("FAIL absorb_op%h: good cycles %0d retired %0d required 20 0",
                 ops[k], good, bus.retired);
      else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_store_reset();
    apply_reset();
    fetch(mk(ADD, 4'd1, 4'd2, 8'h0));
    step();
    step();
    fetch(mk(ST, 4'd4, 4'd0, 8'h33));
    step();
    bus.dmem_ready = 1'b0;
    #1;
    n_checks++;
    if ({bus.dmem_we, bus.rpa, bus.retired} !== {1'b1, 4'd4, 16'd1})
      $display("FAIL store_wait: we %b rpa %0d retired %0d", bus.dmem_we, bus.rpa, bus.retired);
    else n_pass++;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({outs(), bus.retired, bus.imm} !== 56'd0)
      $display("FAIL store_async_reset: got %h required 0", {outs(), bus.retired, bus.imm});
    else n_pass++;
    step();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (outs() !== 32'd0) $display("FAIL store_reset_idle: got %h required 0", outs());
    else n_pass++;
    step();
    #1;
    n_checks++;
    if (bus.imem_req !== 1'b1) $display("FAIL store_reset_fetch: req %b required 1", bus.imem_req);
    else n_pass++;
    step();
  endtask

  task automatic test_saturation();
    int e;
    apply_reset();
    for (int k = 1; k <= 5; k++) begin
      bus2.imem_ready = 1'b1;
      bus2.instr      = mk(NOP, 4'($urandom), 4'($urandom), 8'($urandom));
      step();
      bus2.imem_ready = 1'b0;
      step();
      step();
      #1;
      e = (k > 3) ? 3 : k;
      n_checks++;
      if (bus2.retired !== 2'(e))
        $display("FAIL sat_retired_%0d: got %0d required %0d", k, bus2.retired, e);
      else n_pass++;
    end
    step();
  endtask

  task automatic push(input logic ir, dm, zz, input logic [23:0] ins, input logic [31:0] e);
    cyc_t c;
    c.ir_rdy = ir; c.dm_rdy = dm; c.z = zz; c.instr = ins; c.exp = e;
    c.ret = 16'(ret_m); c.imm = imm_m;
    q.push_back(c);
  endtask

  task automatic bump();
    if (ret_m < 65535) ret_m++;
  endtask

  // What the execute cycle of each opcode should show on the datapath strobes
  function automatic logic [31:0] exec_exp(input logic [3:0] op, ra, rb, input logic [7:0] imm,
                                           input logic zz);
    case (op)
      LDI: return pk(0,0,0,8'h0,2'b00,4'h0,4'h0,ra,1,2'b10,0,0,0,0);
      MUL: return pk(0,0,0,8'h0,2'b11,ra,rb,ra,1,2'b00,0,0,0,0);
      ADD: return pk(0,0,0,8'h0,2'b01,ra,rb,ra,1,2'b00,0,0,0,0);
      SUB: return pk(0,0,0,8'h0,2'b10,ra,rb,ra,1,2'b00,0,0,0,0);
      INC: return pk(0,0,0,8'h0,2'b01,ra,4'hF,ra,1,2'b00,0,0,0,0);
      MV:  return pk(0,0,0,8'h0,2'b00,ra,4'h0,rb,1,2'b11,0,0,0,0);
      JMP: return pk(0,0,1,imm,2'b00,4'h0,4'h0,4'h0,0,2'b00,0,0,0,0);
      JZ:  return pk(0,0,zz,imm,2'b00,4'h0,4'h0,4'h0,0,2'b00,0,0,0,0);
      default: return 32'd0;
    endcase
  endfunction

  // Expand one instruction into its expected cycle-by-cycle behaviour
  task automatic plan_instr(input logic [3:0] op, ra, rb, input logic [7:0] imm,
                            input int fw, mw, output bit ended);
    logic [23:0] word;
    logic [31:0] e;
    logic zz;
    ended = 1'b0;
    word  = mk(op, ra, rb, imm);
    for (int i = 0; i < fw; i++)
      push(0, rnd(), rnd(), 24'($urandom), pk(1,0,0,8'h0,2'b0,4'h0,4'h0,4'h0,0,2'b0,0,0,0,0));
    push(1, rnd(), rnd(), word, pk(1,1,0,8'h0,2'b0,4'h0,4'h0,4'h0,0,2'b0,0,0,0,0));
    imm_m = imm;
    push(rnd(), rnd(), rnd(), 24'($urandom), 32'd0);
    case (op)
      HLT: begin
        repeat (6) push(rnd(), rnd(), rnd(), 24'($urandom),
                        pk(0,0,0,8'h0,2'b0,4'h0,4'h0,4'h0,0,2'b0,0,0,1,0));
        ended = 1'b1;
      end
      LD, ST: begin
        e = pk(0,0,0,8'h0,2'b0,ra,4'h0,4'h0,0,2'b0,op == LD,op == ST,0,0);
        for (int i = 0; i < mw; i++) push(rnd(), 0, rnd(), 24'($urandom), e);
        push(rnd(), 1, rnd(), 24'($urandom), e);
        if (op == LD)
          push(rnd(), rnd(), rnd(), 24'($urandom), pk(0,0,0,8'h0,2'b0,4'h0,4'h0,rb,1,2'b01,0,0,0,0));
        bump();
      end
      NOP, LDI, MUL, MV, ADD, INC, SUB, JZ, JMP: begin
        zz = rnd();
        push(rnd(), rnd(), zz, 24'($urandom), exec_exp(op, ra, rb, imm, zz));
        bump();
      end
      default: begin
        repeat (6) push(rnd(), rnd(), rnd(), 24'($urandom),
                        pk(0,0,0,8'h0,2'b0,4'h0,4'h0,4'h0,0,2'b0,0,0,0,1));
        ended = 1'b1;
      end
    endcase
  endtask

  task automatic test_random();
    logic [3:0] legal [11];
    logic [3:0] op;
    bit ended;
    legal = '{NOP, LDI, MUL, LD, MV, ADD, INC, SUB, JZ, JMP, ST};
    for (int p = 0; p < 25; p++) begin
      apply_reset();
      q.delete();
      ret_m = 0;
      imm_m = 8'h0;
      ended = 1'b0;
      for (int k = 0; k < 8 && !ended; k++) begin
        op = ($urandom_range(0, 99) < 85) ? legal[$urandom_range(0, 10)] : 4'($urandom);
        plan_instr(op, 4'($urandom), 4'($urandom), 8'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), ended);
      end
      if (!ended)
        push(0, rnd(), rnd(), 24'($urandom), pk(1,0,0,8'h0,2'b0,4'h0,4'h0,4'h0,0,2'b0,0,0,0,0));
      foreach (q[i]) begin
        bus.imem_ready = q[i].ir_rdy;
        bus.dmem_ready = q[i].dm_rdy;
        bus.z          = q[i].z;
        bus.instr      = q[i].instr;
        #1;
        n_checks++;
        if ({outs(), bus.retired, bus.imm} !== {q[i].exp, q[i].ret, q[i].imm})
          $display("FAIL random_p%0d_c%0d: got %h/%0d/%h required %h/%0d/%h", p, i,
                   outs(), bus.retired, bus.imm, q[i].exp, q[i].ret, q[i].imm);
        else n_pass++;
        step();
      end
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_add();
    test_jmpz();
    test_load_wait();
    test_absorbing();
    test_store_reset();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
